// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard: default widths, the
// per-entry status flags and a small population-count helper.
package fwd_scoreboard_pkg;

    localparam int WORD_SIZE_DEF  = 16;
    localparam int REG_ADDR_W_DEF = 2;
    localparam int DEPTH_MAX      = 8;

    // Status bits carried by every in-flight entry alongside its address and value.
    typedef struct packed {
        logic valid;   // entry holds a real register-writing instruction
        logic load;    // result comes from memory rather than stage 0
        logic have;    // value field already holds the final result
    } entry_flags_t;

    // Number of set bits in an 8-bit vector; DEPTH never exceeds 8.
    function automatic logic [3:0] popcount8(input logic [7:0] bits);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fwd_lookup.sv
// One read port of the scoreboard: finds the youngest in-flight producer of
// the requested register and either forwards its value or requests a stall.
module fwd_lookup
    import fwd_scoreboard_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = 3,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH*REG_ADDR_W-1:0] addr,
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH*WORD_SIZE-1:0]  live,
    input  logic [REG_ADDR_W-1:0]       rd_addr,
    input  logic                        rd_used,
    input  logic [WORD_SIZE-1:0]        rf_data,
    output logic [WORD_SIZE-1:0]        rd_data,
    output logic                        fwd_hit,
    output logic                        stall
);

    logic                 found_s;
    logic                 hit_ready_s;
    logic [WORD_SIZE-1:0] hit_val_s;

    // Priority search: the lowest-index (youngest) matching entry wins.
    always_comb begin
        found_s     = 1'b0;
        hit_ready_s = 1'b0;
        hit_val_s   = {WORD_SIZE{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (!found_s && valid[i] && (addr[i*REG_ADDR_W +: REG_ADDR_W] == rd_addr)) begin
                found_s     = 1'b1;
                hit_ready_s = ready[i];
                hit_val_s   = live[i*WORD_SIZE +: WORD_SIZE];
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Operand selection and stall request for this port.
    always_comb begin
        rd_data = rf_data;
        fwd_hit = 1'b0;
        stall   = 1'b0;
        if (FWD_EN) begin
            if (found_s && hit_ready_s) begin
                rd_data = hit_val_s;
                fwd_hit = 1'b1;
            end else if (found_s) begin
                stall   = rd_used;
            end else begin
                rd_data = rf_data;
            end
        end else begin
            stall = found_s && rd_used;
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight write tracker and operand forwarder sitting beside the register
// file in ID. One entry per post-decode stage shifts along with the pipeline;
// each read port looks up the youngest producer of its register.
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int DEPTH      = 3,
    parameter int N_RD       = 2,
    parameter int LOAD_STAGE = 1,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          advance,
    input  logic [DEPTH-1:0]              flush,
    input  logic                          issue_we,
    input  logic [REG_ADDR_W-1:0]         issue_addr,
    input  logic                          issue_load,
    input  logic [WORD_SIZE-1:0]          ex_result,
    input  logic [WORD_SIZE-1:0]          mem_result,
    input  logic [N_RD*REG_ADDR_W-1:0]    rd_addr,
    input  logic [N_RD-1:0]               rd_used,
    input  logic [N_RD*WORD_SIZE-1:0]     rf_data,
    output logic [N_RD*WORD_SIZE-1:0]     rd_data,
    output logic [N_RD-1:0]               fwd_hit,
    output logic                          stall,
    output logic [$clog2(DEPTH+1)-1:0]    inflight_cnt
);

    localparam int CNT_W = $clog2(DEPTH+1);

    entry_flags_t            flags_r     [DEPTH];
    logic [REG_ADDR_W-1:0]   addr_r      [DEPTH];
    logic [WORD_SIZE-1:0]    value_r     [DEPTH];
    logic [CNT_W-1:0]        inflight_cnt_r;

    entry_flags_t            flags_nxt_s [DEPTH];
    logic [REG_ADDR_W-1:0]   addr_nxt_s  [DEPTH];
    logic [WORD_SIZE-1:0]    value_nxt_s [DEPTH];
    logic [DEPTH-1:0]        valid_nxt_s;

    logic [WORD_SIZE-1:0]    live_s      [DEPTH];
    logic [DEPTH-1:0]        ready_s;
    logic [DEPTH-1:0]        valid_s;
    logic [DEPTH*REG_ADDR_W-1:0] addr_flat_s;
    logic [DEPTH*WORD_SIZE-1:0]  live_flat_s;
    logic [N_RD-1:0]         port_stall_s;
    logic                    stall_s;

    // Live value of each entry: captured value, else the producing stage's output.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live_s[i]  = value_r[i];
            ready_s[i] = 1'b0;
            if (flags_r[i].have) begin
                live_s[i]  = value_r[i];
                ready_s[i] = 1'b1;
            end else if (!flags_r[i].load && (i == 0)) begin
                live_s[i]  = ex_result;
                ready_s[i] = 1'b1;
            end else if (flags_r[i].load && (i == LOAD_STAGE)) begin
                live_s[i]  = mem_result;
                ready_s[i] = 1'b1;
            end else begin
                live_s[i]  = value_r[i];
                ready_s[i] = 1'b0;
            end
        end
    end

    // Flatten entry state for the per-port lookup instances.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_s[i]                                = flags_r[i].valid;
            addr_flat_s[i*REG_ADDR_W +: REG_ADDR_W]   = addr_r[i];
            live_flat_s[i*WORD_SIZE +: WORD_SIZE]     = live_s[i];
        end
    end

    // Next entry contents: shift or hold, capture live values, then apply flush.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            flags_nxt_s[i] = flags_r[i];
            addr_nxt_s[i]  = addr_r[i];
            value_nxt_s[i] = value_r[i];
        end
        if (advance) begin
            // A stalled issue enters as a bubble.
            flags_nxt_s[0].valid = issue_we && !stall_s;
            flags_nxt_s[0].load  = issue_load;
            flags_nxt_s[0].have  = 1'b0;
            addr_nxt_s[0]        = issue_addr;
            value_nxt_s[0]       = {WORD_SIZE{1'b0}};
            for (int i = 1; i < DEPTH; i++) begin
                flags_nxt_s[i].valid = flags_r[i-1].valid;
                flags_nxt_s[i].load  = flags_r[i-1].load;
                flags_nxt_s[i].have  = ready_s[i-1];
                addr_nxt_s[i]        = addr_r[i-1];
                value_nxt_s[i]       = live_s[i-1];
            end
        end else begin
            // Holding: latch any result that is visible now so it survives producer changes.
            for (int i = 0; i < DEPTH; i++) begin
                flags_nxt_s[i].have = ready_s[i];
                value_nxt_s[i]      = live_s[i];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            flags_nxt_s[i].valid = flags_nxt_s[i].valid & ~flush[i];
            valid_nxt_s[i]       = flags_nxt_s[i].valid;
        end
    end

    // Entry shift register and occupancy counter; reset overrides advance and flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                flags_r[i].valid <= 1'b0;
                flags_r[i].load  <= 1'b0;
                flags_r[i].have  <= 1'b0;
                addr_r[i]        <= {REG_ADDR_W{1'b0}};
                value_r[i]       <= {WORD_SIZE{1'b0}};
            end
            inflight_cnt_r <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                flags_r[i] <= flags_nxt_s[i];
                addr_r[i]  <= addr_nxt_s[i];
                value_r[i] <= value_nxt_s[i];
            end
            inflight_cnt_r <= CNT_W'(popcount8(8'(valid_nxt_s)));
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_port
        fwd_lookup #(
            .WORD_SIZE  (WORD_SIZE),
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .FWD_EN     (FWD_EN)
        ) u_lookup (
            .valid   (valid_s),
            .addr    (addr_flat_s),
            .ready   (ready_s),
            .live    (live_flat_s),
            .rd_addr (rd_addr[p*REG_ADDR_W +: REG_ADDR_W]),
            .rd_used (rd_used[p]),
            .rf_data (rf_data[p*WORD_SIZE +: WORD_SIZE]),
            .rd_data (rd_data[p*WORD_SIZE +: WORD_SIZE]),
            .fwd_hit (fwd_hit[p]),
            .stall   (port_stall_s[p])
        );
    end

    assign stall_s      = |port_stall_s;
    assign stall        = stall_s;
    assign inflight_cnt = inflight_cnt_r;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: a forwarding build and a stall-only
// build share the same stimulus; each scenario task checks its own results.
module tb_fwd_scoreboard;

    localparam int W  = 16;
    localparam int RA = 2;
    localparam int D  = 3;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            advance;
    logic [D-1:0]    flush;
    logic            issue_we;
    logic [RA-1:0]   issue_addr;
    logic            issue_load;
    logic [W-1:0]    ex_result;
    logic [W-1:0]    mem_result;
    logic [NR*RA-1:0] rd_addr;
    logic [NR-1:0]   rd_used;
    logic [NR*W-1:0] rf_data;

    logic [NR*W-1:0] rd_data_f, rd_data_n;
    logic [NR-1:0]   fwd_hit_f, fwd_hit_n;
    logic            stall_f, stall_n;
    logic [1:0]      cnt_f, cnt_n;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(.WORD_SIZE(W), .REG_ADDR_W(RA), .DEPTH(D), .N_RD(NR),
                     .LOAD_STAGE(1), .FWD_EN(1'b1)) dut_f (
        .clk(clk), .reset(reset), .advance(advance), .flush(flush),
        .issue_we(issue_we), .issue_addr(issue_addr), .issue_load(issue_load),
        .ex_result(ex_result), .mem_result(mem_result), .rd_addr(rd_addr),
        .rd_used(rd_used), .rf_data(rf_data), .rd_data(rd_data_f),
        .fwd_hit(fwd_hit_f), .stall(stall_f), .inflight_cnt(cnt_f)
    );

    fwd_scoreboard #(.WORD_SIZE(W), .REG_ADDR_W(RA), .DEPTH(D), .N_RD(NR),
                     .LOAD_STAGE(1), .FWD_EN(1'b0)) dut_n (
        .clk(clk), .reset(reset), .advance(advance), .flush(flush),
        .issue_we(issue_we), .issue_addr(issue_addr), .issue_load(issue_load),
        .ex_result(ex_result), .mem_result(mem_result), .rd_addr(rd_addr),
        .rd_used(rd_used), .rf_data(rf_data), .rd_data(rd_data_n),
        .fwd_hit(fwd_hit_n), .stall(stall_n), .inflight_cnt(cnt_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; advance = 1'b0; flush = 3'b000;
        issue_we = 1'b0; issue_addr = 2'd0; issue_load = 1'b0;
        rd_used = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ex_result = 16'h0000; mem_result = 16'h0000;
        rd_addr = {2'd2, 2'd1}; rf_data = {16'h2222, 16'h1111};
        do_reset();
        rd_used = 2'b11;
        #1;
        checks++; if (cnt_f !== 2'd0) begin fails++; $display("FAIL reset_cnt: got %0d exp 0", cnt_f); end
        checks++; if (stall_f !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b exp 0", stall_f); end
        checks++; if (rd_data_f !== 32'h2222_1111) begin fails++; $display("FAIL reset_rd_data: got %h exp 22221111", rd_data_f); end
        // fill three entries, then reset mid-stream for two cycles
        rd_used = 2'b00; advance = 1'b1; issue_we = 1'b1; issue_load = 1'b0;
        issue_addr = 2'd1; tick();
        issue_addr = 2'd2; tick();
        issue_addr = 2'd3; tick();
        checks++; if (cnt_f !== 2'd3) begin fails++; $display("FAIL fill_cnt: got %0d exp 3", cnt_f); end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0; issue_we = 1'b0; advance = 1'b0;
        rd_addr = {2'd3, 2'd1}; rd_used = 2'b11;
        #1;
        checks++; if (cnt_f !== 2'd0) begin fails++; $display("FAIL midreset_cnt: got %0d exp 0", cnt_f); end
        checks++; if (stall_f !== 1'b0) begin fails++; $display("FAIL midreset_stall: got %b exp 0", stall_f); end
        checks++; if (fwd_hit_f !== 2'b00) begin fails++; $display("FAIL midreset_hit: got %b exp 00", fwd_hit_f); end
    endtask

    task automatic test_alu_b2b();
        do_reset();
        advance = 1'b1; issue_we = 1'b1; issue_addr = 2'd1; issue_load = 1'b0;
        tick();
        issue_we = 1'b0; ex_result = 16'h0005;
        rd_addr = {2'd2, 2'd1}; rd_used = 2'b11; rf_data = {16'h2222, 16'h1111};
        #1;
        checks++; if (rd_data_f[15:0] !== 16'h0005) begin fails++; $display("FAIL alu_fwd: got %h exp 0005", rd_data_f[15:0]); end
        checks++; if (fwd_hit_f !== 2'b01) begin fails++; $display("FAIL alu_hit: got %b exp 01", fwd_hit_f); end
        checks++; if (stall_f !== 1'b0) begin fails++; $display("FAIL alu_stall: got %b exp 0", stall_f); end
        checks++; if (rd_data_f[31:16] !== 16'h2222) begin fails++; $display("FAIL alu_nomatch: got %h exp 2222", rd_data_f[31:16]); end
        checks++; if (cnt_f !== 2'd1) begin fails++; $display("FAIL alu_cnt: got %0d exp 1", cnt_f); end
        tick();
        ex_result = 16'h0009;
        #1;
        checks++; if (rd_data_f[15:0] !== 16'h0005) begin fails++; $display("FAIL alu_stage1: got %h exp 0005", rd_data_f[15:0]); end
        tick();
        checks++; if (rd_data_f[15:0] !== 16'h0005) begin fails++; $display("FAIL alu_stage2: got %h exp 0005", rd_data_f[15:0]); end
        tick();
        checks++; if (rd_data_f[15:0] !== 16'h1111) begin fails++; $display("FAIL alu_retired: got %h exp 1111", rd_data_f[15:0]); end
        checks++; if (cnt_f !== 2'd0) begin fails++; $display("FAIL alu_retired_cnt: got %0d exp 0", cnt_f); end
    endtask

    task automatic test_hold();
        do_reset();
        advance = 1'b1; issue_we = 1'b1; issue_addr = 2'd1; issue_load = 1'b0;
        tick();
        issue_we = 1'b0; advance = 1'b0; ex_result = 16'h0007;
        tick();
        ex_result = 16'h0008; rd_addr = {2'd0, 2'd1}; rd_used = 2'b01;
        #1;
        checks++; if (rd_data_f[15:0] !== 16'h0007) begin fails++; $display("FAIL hold_latch: got %h exp 0007", rd_data_f[15:0]); end
        checks++; if (fwd_hit_f[0] !== 1'b1) begin fails++; $display("FAIL hold_hit: got %b exp 1", fwd_hit_f[0]); end
    endtask

    task automatic test_load_use();
        do_reset();
        advance = 1'b1; issue_we = 1'b1; issue_addr = 2'd2; issue_load = 1'b1;
        tick();
        issue_addr = 2'd3; issue_load = 1'b0; mem_result = 16'hDEAD;
        rd_addr = {2'd2, 2'd2}; rd_used = 2'b00; rf_data = {16'h5555, 16'h4444};
        #1;
        checks++; if (stall_f !== 1'b0) begin fails++; $display("FAIL unused_nostall: got %b exp 0", stall_f); end
        checks++; if (rd_data_f !== 32'h5555_4444) begin fails++; $display("FAIL load_notready_data: got %h exp 55554444", rd_data_f); end
        rd_used = 2'b01;
        #1;
        checks++; if (stall_f !== 1'b1) begin fails++; $display("FAIL load_use_stall: got %b exp 1", stall_f); end
        tick();
        mem_result = 16'hBEEF;
        #1;
        checks++; if (cnt_f !== 2'd1) begin fails++; $display("FAIL bubble_cnt: got %0d exp 1", cnt_f); end
        checks++; if (stall_f !== 1'b0) begin fails++; $display("FAIL load_ready_stall: got %b exp 0", stall_f); end
        checks++; if (rd_data_f !== 32'hBEEF_BEEF) begin fails++; $display("FAIL load_fwd: got %h exp BEEFBEEF", rd_data_f); end
        checks++; if (fwd_hit_f !== 2'b11) begin fails++; $display("FAIL load_hit: got %b exp 11", fwd_hit_f); end
        tick();
        mem_result = 16'h0000; ex_result = 16'h0033;
        #1;
        checks++; if (cnt_f !== 2'd2) begin fails++; $display("FAIL reissue_cnt: got %0d exp 2", cnt_f); end
        checks++; if (rd_data_f[15:0] !== 16'hBEEF) begin fails++; $display("FAIL load_captured: got %h exp BEEF", rd_data_f[15:0]); end
    endtask

    task automatic test_youngest();
        do_reset();
        advance = 1'b1; issue_we = 1'b1; issue_load = 1'b0; issue_addr = 2'd3;
        tick();
        ex_result = 16'h0001; issue_addr = 2'd0;
        tick();
        ex_result = 16'h00AA; issue_addr = 2'd3;
        tick();
        issue_we = 1'b0; ex_result = 16'h0002;
        rd_addr = {2'd3, 2'd0}; rd_used = 2'b11;
        #1;
        checks++; if (rd_data_f[31:16] !== 16'h0002) begin fails++; $display("FAIL youngest: got %h exp 0002", rd_data_f[31:16]); end
        checks++; if (rd_data_f[15:0] !== 16'h00AA) begin fails++; $display("FAIL stage1_fwd: got %h exp 00AA", rd_data_f[15:0]); end
        checks++; if (cnt_f !== 2'd3) begin fails++; $display("FAIL youngest_cnt: got %0d exp 3", cnt_f); end
    endtask

    task automatic test_flush();
        do_reset();
        advance = 1'b1; issue_we = 1'b1; issue_load = 1'b1; issue_addr = 2'd1;
        tick();
        issue_we = 1'b0; advance = 1'b0;
        rd_addr = {2'd0, 2'd1}; rd_used = 2'b01; rf_data = {16'h6666, 16'h7777};
        #1;
        checks++; if (stall_f !== 1'b1) begin fails++; $display("FAIL preflush_stall: got %b exp 1", stall_f); end
        flush = 3'b001;
        tick();
        flush = 3'b000;
        checks++; if (stall_f !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b exp 0", stall_f); end
        checks++; if (rd_data_f[15:0] !== 16'h7777 || fwd_hit_f !== 2'b00) begin
            fails++; $display("FAIL flush_rf: got %h/%b exp 7777/00", rd_data_f[15:0], fwd_hit_f); end
        checks++; if (cnt_f !== 2'd0) begin fails++; $display("FAIL flush_cnt: got %0d exp 0", cnt_f); end
        // flush applies to the post-shift slot
        advance = 1'b1; issue_we = 1'b1; issue_load = 1'b0; issue_addr = 2'd2; rd_used = 2'b00;
        tick();
        issue_addr = 2'd3; flush = 3'b010; ex_result = 16'h0044;
        tick();
        flush = 3'b000; issue_we = 1'b0; advance = 1'b0;
        rd_addr = {2'd3, 2'd2}; rd_used = 2'b11;
        #1;
        checks++; if (cnt_f !== 2'd1) begin fails++; $display("FAIL shift_flush_cnt: got %0d exp 1", cnt_f); end
        checks++; if (fwd_hit_f !== 2'b10) begin fails++; $display("FAIL shift_flush_hit: got %b exp 10", fwd_hit_f); end
        checks++; if (rd_data_f !== 32'h0044_7777) begin fails++; $display("FAIL shift_flush_data: got %h exp 00447777", rd_data_f); end
    endtask

    task automatic test_fwd_disabled();
        do_reset();
        advance = 1'b1; issue_we = 1'b1; issue_load = 1'b0; issue_addr = 2'd0;
        ex_result = 16'h00C0;
        tick();
        issue_we = 1'b0;
        tick();
        rd_addr = {2'd1, 2'd0}; rd_used = 2'b01; rf_data = {16'h9999, 16'h4444};
        #1;
        checks++; if (stall_n !== 1'b1) begin fails++; $display("FAIL nofwd_stall: got %b exp 1", stall_n); end
        checks++; if (rd_data_n[15:0] !== 16'h4444 || fwd_hit_n !== 2'b00) begin
            fails++; $display("FAIL nofwd_data: got %h/%b exp 4444/00", rd_data_n[15:0], fwd_hit_n); end
        checks++; if (stall_f !== 1'b0 || rd_data_f[15:0] !== 16'h00C0) begin
            fails++; $display("FAIL fwd_compare: got %b/%h exp 0/00C0", stall_f, rd_data_f[15:0]); end
        tick();
        checks++; if (stall_n !== 1'b1) begin fails++; $display("FAIL nofwd_stage2_stall: got %b exp 1", stall_n); end
        tick();
        checks++; if (stall_n !== 1'b0) begin fails++; $display("FAIL nofwd_retired_stall: got %b exp 0", stall_n); end
        checks++; if (cnt_n !== 2'd0) begin fails++; $display("FAIL nofwd_cnt: got %0d exp 0", cnt_n); end
    endtask

    initial begin
        test_reset();
        test_alu_b2b();
        test_hold();
        test_load_use();
        test_youngest();
        test_flush();
        test_fwd_disabled();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
